// File: rtl/rapcla_error_corrector.sv
// Exact-result post-stage for the reconfigurable approximate CLA.
// Re-adds one group per cycle, flags wrong groups, counts bad results.
module rapcla_error_corrector #(
  parameter int SIZE      = 16,
  parameter int GROUPSIZE = 8,
  parameter int WINDOW    = 4,
  parameter int CNTW      = 8
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [SIZE-1:0]           A,
  input  logic [SIZE-1:0]           B,
  input  logic                      CIN,
  input  logic [SIZE-1:0]           ASUM,
  input  logic                      ACOUT,
  input  logic [SIZE/GROUPSIZE-1:0] RCON,
  input  logic                      BYPASS,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [SIZE-1:0]           SUM,
  output logic                      COUT,
  output logic [SIZE/GROUPSIZE-1:0] ERR_GROUPS,
  output logic                      ERR_ANY,
  input  logic                      CLR_COUNT,
  output logic [CNTW-1:0]           ERR_COUNT
);

  localparam int NG = SIZE / GROUPSIZE;
  localparam int IW = (NG > 1) ? $clog2(NG) : 1;

  if (SIZE % GROUPSIZE != 0) begin : g_bad_size
    $error("SIZE must be a multiple of GROUPSIZE");
  end
  if (WINDOW >= GROUPSIZE) begin : g_bad_window
    $error("WINDOW must be smaller than GROUPSIZE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIX  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state;

  logic [SIZE-1:0]      a_q;
  logic [SIZE-1:0]      b_q;
  logic [SIZE-1:0]      asum_q;
  logic                 acout_q;
  logic                 carry;
  logic [IW-1:0]        gi;

  logic [GROUPSIZE-1:0] ga;
  logic [GROUPSIZE-1:0] gb;
  logic [GROUPSIZE-1:0] gref;
  logic [GROUPSIZE:0]   gsum;
  logic [SIZE-1:0]      sum_nx;
  logic [NG-1:0]        eg_nx;
  logic                 last;
  logic                 hs;

  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == OUT);
  assign hs        = OUT_VALID & OUT_READY;
  assign last      = (gi == IW'(NG - 1));

  // Slice out the current group and add it with the running carry
  always_comb begin
    ga     = '0;
    gb     = '0;
    gref   = '0;
    sum_nx = SUM;
    eg_nx  = ERR_GROUPS;
    for (int j = 0; j < NG; j++) begin
      if (gi == IW'(j)) begin
        ga   = a_q[j*GROUPSIZE +: GROUPSIZE];
        gb   = b_q[j*GROUPSIZE +: GROUPSIZE];
        gref = asum_q[j*GROUPSIZE +: GROUPSIZE];
      end
    end
    gsum = {1'b0, ga} + {1'b0, gb}
         + {{GROUPSIZE{1'b0}}, carry};
    for (int j = 0; j < NG; j++) begin
      if (gi == IW'(j)) begin
        sum_nx[j*GROUPSIZE +: GROUPSIZE] =
          gsum[GROUPSIZE-1:0];
        eg_nx[j] = (gsum[GROUPSIZE-1:0] != gref);
      end
    end
  end

  // Control FSM: accept, fix group-serially, hold result
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      asum_q     <= '0;
      acout_q    <= 1'b0;
      carry      <= 1'b0;
      gi         <= '0;
      SUM        <= '0;
      COUT       <= 1'b0;
      ERR_GROUPS <= '0;
      ERR_ANY    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (IN_VALID) begin
            a_q     <= A;
            b_q     <= B;
            asum_q  <= ASUM;
            acout_q <= ACOUT;
            if (BYPASS && (RCON == '0)) begin
              SUM        <= ASUM;
              COUT       <= ACOUT;
              ERR_GROUPS <= '0;
              ERR_ANY    <= 1'b0;
              state      <= OUT;
            end else begin
              carry <= CIN;
              gi    <= '0;
              state <= FIX;
            end
          end
        end
        FIX: begin
          SUM        <= sum_nx;
          ERR_GROUPS <= eg_nx;
          carry      <= gsum[GROUPSIZE];
          if (last) begin
            COUT    <= gsum[GROUPSIZE];
            ERR_ANY <= (|eg_nx)
                     | (gsum[GROUPSIZE] != acout_q);
            state   <= OUT;
          end else begin
            gi <= gi + IW'(1);
          end
        end
        OUT: begin
          if (OUT_READY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of delivered erroneous results
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ERR_COUNT <= '0;
    end else if (CLR_COUNT) begin
      ERR_COUNT <= '0;
    end else if (hs && ERR_ANY && (ERR_COUNT != '1)) begin
      ERR_COUNT <= ERR_COUNT + CNTW'(1);
    end
  end

endmodule

// File: doc/rapcla_error_corrector.md
Name: rapcla_error_corrector

Overview:
- Sequential post-stage for the reconfigurable approximate carry-lookahead adder. It receives one transaction per handshake: the operands, carry-in, approximate SUM/COUT and the per-group ApproxRCON vector used to produce them.
- It recomputes the exact result group-serially, one GROUPSIZE-bit slice per cycle, so no full-width carry chain exists in a single cycle.
- It flags which groups were wrong and keeps a saturating error count used to tune approximation settings.

Parameters:
- SIZE, 16, operand width; must be a multiple of GROUPSIZE.
- GROUPSIZE, 8, group width, same meaning as in the adder; NG = SIZE/GROUPSIZE.
- WINDOW, 4, approximation window of the adder; must be < GROUPSIZE. Informational only; affects no logic.
- CNTW, 8, ERR_COUNT width.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- IN_VALID  in  1  input transaction valid.
- IN_READY  out  1  block can accept a transaction.
- A, B  in  SIZE  operands, bit 1 = LSB.
- CIN  in  1  carry-in.
- ASUM  in  SIZE  approximate sum.
- ACOUT  in  1  approximate carry-out.
- RCON  in  NG  ApproxRCON used by the adder; 1 = group approximated.
- BYPASS  in  1  sampled with input; allows pass-through when RCON is all zero.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- SUM  out  SIZE  exact sum.
- COUT  out  1  exact carry-out.
- ERR_GROUPS  out  NG  bit j = group j sum bits (j*GROUPSIZE .. (j-1)*GROUPSIZE+1) differed from ASUM.
- ERR_ANY  out  1  OR of ERR_GROUPS, plus (COUT != ACOUT).
- CLR_COUNT  in  1  synchronous clear of ERR_COUNT.
- ERR_COUNT  out  CNTW  count of delivered results with ERR_ANY=1.

Behaviour:
- Reset (RSTN low, asynchronous): state IDLE. All outputs 0 except IN_READY=1. Carry register, group index and ERR_COUNT are cleared. Any in-flight transaction is discarded with no output.
- States: IDLE, FIX, OUT.
- IDLE:
  - IN_READY=1, OUT_VALID=0.
  - On IN_VALID at an edge, register A, B, CIN, ASUM, ACOUT, RCON.
  - If BYPASS=1 and RCON==0: load SUM=ASUM, COUT=ACOUT, ERR_GROUPS=0, ERR_ANY=0, and go to OUT. Latency is 1 edge.
  - Otherwise set carry reg = CIN, idx = 1, and go to FIX.
- FIX (IN_READY=0), one edge per group:
  - Compute {c, s} = A_grp(idx) + B_grp(idx) + carry.
  - Write s into SUM slice idx. Set ERR_GROUPS[idx] = (s != ASUM slice idx). Set carry = c.
  - When idx==NG: COUT=c, ERR_ANY = |ERR_GROUPS | (c != ACOUT), go to OUT. Otherwise idx++.
  - Exact-path latency: OUT_VALID is high after NG edges following acceptance.
- OUT:
  - OUT_VALID=1. SUM, COUT, ERR_GROUPS and ERR_ANY stay stable until OUT_READY.
  - On OUT_VALID and OUT_READY, go to IDLE. The next input can be accepted on the following edge at the earliest, so there is no overlap and throughput is at most 1 per NG+2 cycles.
  - Output registers keep their last values after the handshake; OUT_VALID qualifies them.
- ERR_COUNT:
  - Increments by 1 on the output handshake when ERR_ANY=1.
  - Saturates at 2^CNTW-1.
  - CLR_COUNT has priority: a clear coincident with an increment gives 0.
- Error locality: an approximation error in group i shows up in ERR_GROUPS[i+1], or in COUT for i=NG. ERR_GROUPS[1] is set only if the adder is faulty.
- Width rules: each group add is GROUPSIZE+1 bits. Comparisons are exact bitwise.
- Inputs are ignored outside IDLE. IN_VALID held high during FIX/OUT is not accepted until IDLE.

Test Plan:
- Reset mid-FIX: assert RSTN low while idx=2 -> immediately IN_READY=1, OUT_VALID=0, ERR_COUNT=0, no result is ever delivered.
- Correction (SIZE=16, G=8): A=0x00F1, B=0x000F, CIN=0, ASUM=0x0000, ACOUT=0, RCON=2'b01, BYPASS=0 -> after 2 edges OUT_VALID=1, SUM=0x0100, COUT=0, ERR_GROUPS=2'b10, ERR_ANY=1; ERR_COUNT 0->1 at the handshake.
- COUT error: A=0xF0FF, B=0x0F01, CIN=0, ASUM=0x0000, ACOUT=0, RCON=2'b10 -> SUM=0x0000, COUT=1, ERR_GROUPS=2'b00, ERR_ANY=1.
- Bypass: BYPASS=1, RCON=0, ASUM=0x1234, ACOUT=1 -> OUT_VALID after 1 edge, SUM=0x1234, COUT=1, ERR_ANY=0. Same inputs with RCON=2'b01 -> exact path with 2-edge latency.
- Backpressure: hold OUT_READY=0 for 5 cycles with IN_VALID=1 -> outputs stable, IN_READY=0, no second accept; accept occurs on the edge after OUT_READY=1.
- Counter: CNTW=2, deliver 5 erroneous results -> ERR_COUNT 1,2,3,3,3. Assert CLR_COUNT on the 6th erroneous handshake -> 0.
